axi_lite_rsa_master: RTL and testbench
======================================

AXI_LITE_RSA_MASTER -- requirements
Module: axi_lite_rsa_master

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 16: AXI address width.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32: AXI data width.
REQ-003 Parameters KEY_ADDR 'hFFF8, START_ADDR 'hFFFC, READY_ADDR 'h0000, RESULT_ADDR 'h0004: peripheral register map.
REQ-004 Parameter POLL_MAX, default 10000: ready-poll read limit.
REQ-005 One clock, M_AXI_ACLK; reset M_AXI_ARESET is synchronous and active-high.
REQ-006 M_AXI_ACLK input 1: clock, all logic on rising edge.
REQ-007 M_AXI_ARESET input 1: synchronous active-high reset.
REQ-008 cmd_valid input 1 / cmd_ready output 1: operation request handshake.
REQ-009 cmd_key input 32: key-select word, captured on cmd handshake.
REQ-010 rsp_valid output 1: one-cycle pulse, operation finished.
REQ-011 rsp_result output 32, rsp_timeout output 1, rsp_error output 1: held from rsp_valid until next command accepted.
REQ-012 M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB(4)/WVALID/WREADY, BRESP(2)/BVALID/BREADY: AXI4-Lite write channels, master side.
REQ-013 M_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP(2)/RVALID/RREADY: AXI4-Lite read channels, master side.

Function
REQ-014 States: IDLE, WR_KEY, WR_KEY_B, WR_START, WR_START_B, POLL_AR, POLL_R, RES_AR, RES_R, DONE.
REQ-015 IDLE: cmd_ready=1; cmd_valid&cmd_ready -> latch cmd_key, clear rsp_* flags, poll counter=0, go WR_KEY.
REQ-016 WR_KEY: AWADDR=KEY_ADDR, WDATA=latched key, WSTRB=4'hF; AWVALID and WVALID rise same cycle; each drops independently on its own READY handshake; go WR_KEY_B when both handshakes done (same or different cycles).
REQ-017 WR_x_B: BREADY=1; on BVALID: BRESP!=0 -> set rsp_error, go DONE; else advance (WR_KEY_B->WR_START, WR_START_B->POLL_AR).
REQ-018 WR_START: as WR_KEY with AWADDR=START_ADDR, WDATA=32'h1.
REQ-019 POLL_AR / RES_AR: ARVALID=1, ARADDR=READY_ADDR / RESULT_ADDR, held until ARREADY; then to POLL_R / RES_R.
REQ-020 POLL_R: RREADY=1; on RVALID: RRESP!=0 -> rsp_error, DONE; RDATA[0]=1 -> RES_AR; else counter+1; counter reaching POLL_MAX -> rsp_timeout, DONE; else POLL_AR.
REQ-021 RES_R: RREADY=1; on RVALID capture RDATA into rsp_result; RRESP!=0 -> rsp_error; go DONE.
REQ-022 DONE: rsp_valid=1 for exactly one cycle, next state IDLE; cmd_ready=0 in DONE.
REQ-023 VALID signals never deasserted before handshake; address/data stable while VALID high.
REQ-024 Only one outstanding AXI transaction; AW/W never overlap AR.
REQ-025 Poll counter 14 bits minimum, saturating; no wrap.
REQ-026 BREADY/RREADY low outside their wait states; unexpected BVALID/RVALID ignored.
REQ-027 cmd_valid outside IDLE ignored, not queued.
REQ-028 Latency from cmd handshake to rsp_valid with zero-wait slave and ready on first poll: 10 cycles, constant.

Reset
REQ-029 Reset forces IDLE; AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, rsp_error = 0; rsp_result=0; poll counter=0; cmd_ready=1 first cycle after release.
REQ-030 Reset mid-transaction abandons it immediately; no VALID held across reset.

Verification
REQ-031 Key 32'h3, zero-wait slave, ready=1 first poll, result 32'hDEADBEEF -> writes FFF8=3, FFFC=1, one read @0, one @4; rsp_valid once, rsp_result=DEADBEEF, flags 0.
REQ-032 Slave returns ready=0 for 5 polls then 1 -> exactly 6 reads @0 before read @4; rsp_timeout=0.
REQ-033 POLL_MAX=4, ready stuck 0 -> 4 polls, no read @4, rsp_timeout=1, rsp_valid pulse.
REQ-034 AWREADY 3 cycles after WREADY, and reversed -> each valid drops on own handshake, one write each, no duplicate.
REQ-035 BRESP=2'b10 on key write -> no START write, rsp_error=1, rsp_valid next.
REQ-036 Reset asserted in POLL_R with ARVALID/RREADY active -> all VALID/READY low next cycle, cmd_ready=1 after release, new command completes normally.

Source files
------------

// File: rtl/axi_lite_rsa_master.sv
// AXI4-Lite master that drives an RSA peripheral through one operation:
// write key select, write start, poll ready, read result, report.
// One AXI transaction is in flight at a time; responses are held until
// the next command is accepted.
module axi_lite_rsa_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] KEY_ADDR    = 'hFFF8,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] START_ADDR  = 'hFFFC,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] READY_ADDR  = 'h0000,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] RESULT_ADDR = 'h0004,
    parameter int unsigned POLL_MAX = 10000
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [31:0]                       cmd_key,
    output logic                              rsp_valid,
    output logic [31:0]                       rsp_result,
    output logic                              rsp_timeout,
    output logic                              rsp_error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WR_KEY     = 4'd1;
    localparam logic [3:0] S_WR_KEY_B   = 4'd2;
    localparam logic [3:0] S_WR_START   = 4'd3;
    localparam logic [3:0] S_WR_START_B = 4'd4;
    localparam logic [3:0] S_POLL_AR    = 4'd5;
    localparam logic [3:0] S_POLL_R     = 4'd6;
    localparam logic [3:0] S_RES_AR     = 4'd7;
    localparam logic [3:0] S_RES_R      = 4'd8;
    localparam logic [3:0] S_DONE       = 4'd9;

    localparam int unsigned CNT_RAW = $clog2(POLL_MAX + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 14) ? CNT_RAW : 14;
    localparam logic [CNT_W-1:0] POLL_LIMIT = CNT_W'(POLL_MAX);

    logic [3:0]       state_q, state_d;
    logic [31:0]      key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      result_q, result_d;
    logic             timeout_q, timeout_d;
    logic             error_q, error_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             in_write;

    // AXI and command outputs decoded straight from state so nothing lingers across reset
    always_comb begin
        in_write      = (state_q == S_WR_KEY) || (state_q == S_WR_START);
        cmd_ready     = (state_q == S_IDLE);
        rsp_valid     = (state_q == S_DONE);
        rsp_result    = result_q;
        rsp_timeout   = timeout_q;
        rsp_error     = error_q;
        M_AXI_AWADDR  = (state_q == S_WR_START) ? START_ADDR : KEY_ADDR;
        M_AXI_AWVALID = in_write && !aw_done_q;
        M_AXI_WDATA   = (state_q == S_WR_START) ? C_M_AXI_DATA_WIDTH'(32'd1)
                                                : C_M_AXI_DATA_WIDTH'(key_q);
        M_AXI_WSTRB   = '1;
        M_AXI_WVALID  = in_write && !w_done_q;
        M_AXI_BREADY  = (state_q == S_WR_KEY_B) || (state_q == S_WR_START_B);
        M_AXI_ARADDR  = (state_q == S_RES_AR) ? RESULT_ADDR : READY_ADDR;
        M_AXI_ARVALID = (state_q == S_POLL_AR) || (state_q == S_RES_AR);
        M_AXI_RREADY  = (state_q == S_POLL_R) || (state_q == S_RES_R);
    end

    // Sequencer next-state and response bookkeeping
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        error_d   = error_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    key_d     = cmd_key;
                    timeout_d = 1'b0;
                    error_d   = 1'b0;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_KEY;
                end
            end
            S_WR_KEY, S_WR_START: begin
                // Address and data handshakes are tracked separately so
                // either channel may complete first without being re-sent.
                aw_done_d = aw_done_q || M_AXI_AWREADY;
                w_done_d  = w_done_q  || M_AXI_WREADY;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (state_q == S_WR_KEY) ? S_WR_KEY_B : S_WR_START_B;
                end
            end
            S_WR_KEY_B, S_WR_START_B: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = (state_q == S_WR_KEY_B) ? S_WR_START : S_POLL_AR;
                    end
                end
            end
            S_POLL_AR: begin
                if (M_AXI_ARREADY) state_d = S_POLL_R;
            end
            S_POLL_R: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (M_AXI_RDATA[0]) begin
                        state_d = S_RES_AR;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= POLL_LIMIT) begin
                            timeout_d = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            state_d   = S_POLL_AR;
                        end
                    end
                end
            end
            S_RES_AR: begin
                if (M_AXI_ARREADY) state_d = S_RES_R;
            end
            S_RES_R: begin
                if (M_AXI_RVALID) begin
                    result_d = 32'(M_AXI_RDATA);
                    if (M_AXI_RRESP != 2'b00) error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            error_q   <= error_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_rsa_master.sv
// Directed plus randomized bench for axi_lite_rsa_master with a
// configurable AXI4-Lite slave and an outcome model of each operation.
module tb_axi_lite_rsa_master;

    localparam int unsigned TB_POLL_MAX = 6;
    localparam logic [15:0] A_KEY    = 16'hFFF8;
    localparam logic [15:0] A_START  = 16'hFFFC;
    localparam logic [15:0] A_READY  = 16'h0000;
    localparam logic [15:0] A_RESULT = 16'h0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_key = '0;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_timeout, rsp_error;
    logic [15:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    int vectors = 0;
    int miscompares = 0;

    // slave configuration
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, ready_after = 0;
    logic [31:0] result_val = '0;
    logic [1:0]  bresp_key = '0, bresp_start = '0, rresp_res = '0;
    int          poll_base = 0;

    // slave state / logs
    int          aw_wait, w_wait, ar_wait;
    int          aw_hs = 0, w_hs = 0, total_polls = 0;
    bit          aw_got, w_got;
    logic [15:0] aw_addr_l;
    logic [31:0] w_data_l;
    logic [15:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [15:0] rd_addr_log[$];
    int          proto_err = 0;

    always #5 clk = ~clk;

    axi_lite_rsa_master #(.POLL_MAX(TB_POLL_MAX)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_timeout(rsp_timeout), .rsp_error(rsp_error),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid  && (w_wait  >= w_delay);
    assign arready = arvalid && (ar_wait >= ar_delay);

    // slave: programmable ready delays, one-cycle B/R response after handshake
    always @(posedge clk) begin
        if (rst) begin
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= '0; rresp <= '0; rdata <= '0;
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_got = 1'b0; w_got = 1'b0;
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (rvalid && rready) rvalid <= 1'b0;
            if (awvalid && awready) begin
                aw_got = 1'b1; aw_addr_l = awaddr; aw_wait <= 0; aw_hs++;
            end else if (awvalid) aw_wait <= aw_wait + 1;
            if (wvalid && wready) begin
                w_got = 1'b1; w_data_l = wdata; w_wait <= 0; w_hs++;
            end else if (wvalid) w_wait <= w_wait + 1;
            if (aw_got && w_got) begin
                wr_addr_log.push_back(aw_addr_l);
                wr_data_log.push_back(w_data_l);
                aw_got = 1'b0; w_got = 1'b0;
                bvalid <= 1'b1;
                bresp  <= (aw_addr_l == A_KEY) ? bresp_key : bresp_start;
            end
            if (arvalid && arready) begin
                rd_addr_log.push_back(araddr);
                ar_wait <= 0;
                rvalid  <= 1'b1;
                if (araddr == A_READY) begin
                    rdata <= ($urandom & 32'hFFFF_FFFE) | 32'((total_polls - poll_base) >= ready_after);
                    rresp <= 2'b00;
                    total_polls++;
                end else begin
                    rdata <= result_val;
                    rresp <= rresp_res;
                end
            end else if (arvalid) ar_wait <= ar_wait + 1;
        end
    end

    // protocol monitor: AR never overlaps AW/W, VALID and payload stable until handshake
    bit          p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [15:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    always @(posedge clk) begin
        if (!rst) begin
            if (arvalid && (awvalid || wvalid)) proto_err++;
            if (p_aw && (!awvalid || awaddr !== p_awaddr)) proto_err++;
            if (p_w  && (!wvalid  || wdata  !== p_wdata))  proto_err++;
            if (p_ar && (!arvalid || araddr !== p_araddr)) proto_err++;
        end
        p_aw = !rst && awvalid && !awready; p_awaddr = awaddr;
        p_w  = !rst && wvalid  && !wready;  p_wdata  = wdata;
        p_ar = !rst && arvalid && !arready; p_araddr = araddr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [31:0] key, input int ra, input logic [31:0] res,
                           input logic [1:0] bk, input logic [1:0] bs, input logic [1:0] rr,
                           input int awd, input int wd, input int ard, input bit chk_lat);
        int exp_w, exp_p, exp_r, wbase, rbase, awb, wb, cyc, n0, n4, nw;
        bit exp_to, exp_err;
        // outcome model
        exp_to = 1'b0; exp_err = 1'b0; exp_p = 0; exp_r = 0;
        if (bk != 2'b00) begin
            exp_w = 1; exp_err = 1'b1;
        end else begin
            exp_w = 2;
            if (bs != 2'b00) exp_err = 1'b1;
            else if (ra >= int'(TB_POLL_MAX)) begin exp_p = TB_POLL_MAX; exp_to = 1'b1; end
            else begin exp_p = ra + 1; exp_r = 1; exp_err = (rr != 2'b00); end
        end
        ready_after = ra; result_val = res; bresp_key = bk; bresp_start = bs; rresp_res = rr;
        aw_delay = awd; w_delay = wd; ar_delay = ard;
        wbase = wr_addr_log.size(); rbase = rd_addr_log.size();
        awb = aw_hs; wb = w_hs; poll_base = total_polls;

        cmd_key = key; cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0; cyc = 1;
        while (!rsp_valid && cyc < 2000) begin
            if (cyc == 3) begin cmd_valid = 1'b1; cmd_key = ~key; end
            else cmd_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check("rsp_seen", rsp_valid, 1);
        if (chk_lat) check("latency", cyc + 1, 10);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("rsp_error", rsp_error, exp_err);
        if (exp_r != 0) check("rsp_result", rsp_result, res);
        @(negedge clk);
        check("rsp_pulse", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
        check("timeout_held", rsp_timeout, exp_to);
        check("error_held", rsp_error, exp_err);
        if (exp_r != 0) check("result_held", rsp_result, res);
        @(negedge clk);
        check("not_queued", cmd_ready, 1);

        nw = wr_addr_log.size() - wbase;
        check("n_writes", nw, exp_w);
        check("aw_handshakes", aw_hs - awb, exp_w);
        check("w_handshakes", w_hs - wb, exp_w);
        if (nw >= 1) begin
            check("key_addr", wr_addr_log[wbase], A_KEY);
            check("key_data", wr_data_log[wbase], key);
        end
        if (nw >= 2 && exp_w == 2) begin
            check("start_addr", wr_addr_log[wbase+1], A_START);
            check("start_data", wr_data_log[wbase+1], 32'h1);
        end
        n0 = 0; n4 = 0;
        for (int i = rbase; i < rd_addr_log.size(); i++) begin
            if (rd_addr_log[i] == A_READY) n0++;
            else if (rd_addr_log[i] == A_RESULT) n4++;
        end
        check("poll_reads", n0, exp_p);
        check("result_reads", n4, exp_r);
        if (exp_r != 0 && rd_addr_log.size() > rbase)
            check("result_last", rd_addr_log[rd_addr_log.size()-1], A_RESULT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] bk, bs, rr;
        int guard;
        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_flags", {rsp_timeout, rsp_error}, 0);
        check("rst_result", rsp_result, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_cmd_ready", cmd_ready, 1);

        // zero-wait, ready on first poll, fixed latency
        run_txn(32'h3, 0, 32'hDEADBEEF, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b1);
        // five not-ready polls then ready
        run_txn(32'h11, 5, 32'h12345678, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b0);
        // ready never seen within the poll limit
        run_txn(32'h22, TB_POLL_MAX, 32'h0BADF00D, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b0);
        // AWREADY late relative to WREADY, and the reverse
        run_txn(32'h44, 1, 32'hCAFE0001, 2'b00, 2'b00, 2'b00, 3, 0, 0, 1'b0);
        run_txn(32'h55, 0, 32'hCAFE0002, 2'b00, 2'b00, 2'b00, 0, 3, 0, 1'b0);
        // slave error on key write
        run_txn(32'h66, 0, 32'h0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1'b0);

        // reset while waiting on a poll read
        ready_after = 1000; aw_delay = 0; w_delay = 0; ar_delay = 0;
        bresp_key = '0; bresp_start = '0; rresp_res = '0; poll_base = total_polls;
        cmd_key = 32'h77; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!rready && guard < 200) begin @(negedge clk); guard++; end
        check("pre_rst_rready", rready, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check("mid_rst_flags", {rsp_timeout, rsp_error}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_cmd_ready", cmd_ready, 1);
        run_txn(32'h88, 2, 32'hA5A5A5A5, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b0);

        // randomized operations
        for (int n = 0; n < 25; n++) begin
            bk = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn($urandom, $urandom_range(0, 8), $urandom, bk, bs, rr,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        check("protocol_violations", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
